// File: rtl/id_ex_lane_reg.sv
// ID->EX pipeline register for an N-lane in-order core: per-lane valid/PC/payload,
// lane-granular branch-mispredict kill, and saturating bubble/flush counters.
module id_ex_lane_reg #(
    parameter int LANES        = 2,
    parameter int ADDR_W       = 32,
    parameter int PAYLOAD_W    = 192,
    parameter int ZERO_ON_KILL = 1,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_exc,
    input  logic                       flush_bp,
    input  logic [LANES-1:0]           bp_keep_mask,
    input  logic                       stall_id,
    input  logic                       stall_ex,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*ADDR_W-1:0]    in_addr,
    input  logic [LANES*PAYLOAD_W-1:0] in_payload,
    input  logic                       in_dslot_next,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*ADDR_W-1:0]    out_addr,
    output logic [LANES*PAYLOAD_W-1:0] out_payload,
    output logic                       out_dslot_next,
    output logic [CNT_W-1:0]           bubble_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    logic                       do_exc;
    logic                       do_bp;
    logic                       do_bubble;
    logic                       do_load;
    logic [LANES-1:0]           eff_keep;
    logic [LANES-1:0]           valid_nxt;
    logic [LANES*ADDR_W-1:0]    addr_nxt;
    logic [LANES*PAYLOAD_W-1:0] payload_nxt;
    logic                       dslot_nxt;

    assign do_exc    = flush_exc;
    assign do_bp     = !flush_exc && flush_bp;
    assign do_bubble = !flush_exc && !flush_bp && stall_id && !stall_ex;
    assign do_load   = !flush_exc && !flush_bp && !stall_id;

    // A lane survives a mispredict only if every lower lane survives too.
    always_comb begin
        eff_keep    = '0;
        eff_keep[0] = bp_keep_mask[0];
        for (int i = 1; i < LANES; i++) begin
            eff_keep[i] = eff_keep[i-1] & bp_keep_mask[i];
        end
    end

    always_comb begin
        valid_nxt   = out_valid;
        addr_nxt    = out_addr;
        payload_nxt = out_payload;
        dslot_nxt   = out_dslot_next;
        for (int i = 0; i < LANES; i++) begin
            if (do_load || (do_bp && eff_keep[i])) begin
                valid_nxt[i]                          = in_valid[i];
                addr_nxt[i*ADDR_W +: ADDR_W]          = in_addr[i*ADDR_W +: ADDR_W];
                payload_nxt[i*PAYLOAD_W +: PAYLOAD_W] = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end else if (do_exc || do_bubble || do_bp) begin
                valid_nxt[i] = 1'b0;
                if (ZERO_ON_KILL != 0) begin
                    addr_nxt[i*ADDR_W +: ADDR_W]          = '0;
                    payload_nxt[i*PAYLOAD_W +: PAYLOAD_W] = '0;
                end
            end
        end
        if (do_exc) begin
            dslot_nxt = 1'b0;
        end else if (do_bp || do_bubble || do_load) begin
            dslot_nxt = in_dslot_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= '0;
            out_addr       <= '0;
            out_payload    <= '0;
            out_dslot_next <= 1'b0;
            bubble_cnt     <= '0;
            flush_cnt      <= '0;
        end else begin
            out_valid      <= valid_nxt;
            out_addr       <= addr_nxt;
            out_payload    <= payload_nxt;
            out_dslot_next <= dslot_nxt;
            if (do_bubble && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if ((do_exc || do_bp) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_lane_reg.sv
// Directed bench for id_ex_lane_reg: default 2-lane build, a 4-bit-counter build
// sharing its inputs, and a 4-lane hold-on-kill build.
module tb_id_ex_lane_reg;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 2-lane default build and 4-bit counter build share these inputs
    logic         rst, flush_exc, flush_bp, stall_id, stall_ex, in_dslot_next;
    logic [1:0]   bp_keep_mask, in_valid;
    logic [63:0]  in_addr;
    logic [383:0] in_payload;
    logic [1:0]   out_valid, s_out_valid;
    logic [63:0]  out_addr, s_out_addr;
    logic [383:0] out_payload, s_out_payload;
    logic         out_dslot_next, s_out_dslot_next;
    logic [15:0]  bubble_cnt, flush_cnt;
    logic [3:0]   s_bubble_cnt, s_flush_cnt;

    // 4-lane, ZERO_ON_KILL=0 build
    logic         d_rst, d_flush_exc, d_flush_bp, d_stall_id, d_stall_ex, d_in_dslot;
    logic [3:0]   d_keep, d_in_valid, d_out_valid;
    logic [127:0] d_in_addr, d_out_addr;
    logic [767:0] d_in_payload, d_out_payload;
    logic         d_out_dslot;
    logic [15:0]  d_bubble_cnt, d_flush_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [191:0] P_A5 = {24{8'hA5}};
    localparam logic [191:0] P_5A = {24{8'h5A}};
    localparam logic [191:0] P0   = {6{32'h1111_0000}};
    localparam logic [191:0] P1   = {6{32'h2222_0001}};
    localparam logic [191:0] Q0   = {6{32'h3333_0002}};

    id_ex_lane_reg u_dut (
        .clk(clk), .rst(rst), .flush_exc(flush_exc), .flush_bp(flush_bp),
        .bp_keep_mask(bp_keep_mask), .stall_id(stall_id), .stall_ex(stall_ex),
        .in_valid(in_valid), .in_addr(in_addr), .in_payload(in_payload),
        .in_dslot_next(in_dslot_next), .out_valid(out_valid), .out_addr(out_addr),
        .out_payload(out_payload), .out_dslot_next(out_dslot_next),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_lane_reg #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush_exc(flush_exc), .flush_bp(flush_bp),
        .bp_keep_mask(bp_keep_mask), .stall_id(stall_id), .stall_ex(stall_ex),
        .in_valid(in_valid), .in_addr(in_addr), .in_payload(in_payload),
        .in_dslot_next(in_dslot_next), .out_valid(s_out_valid), .out_addr(s_out_addr),
        .out_payload(s_out_payload), .out_dslot_next(s_out_dslot_next),
        .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    id_ex_lane_reg #(.LANES(4), .ZERO_ON_KILL(0)) u_d4 (
        .clk(clk), .rst(d_rst), .flush_exc(d_flush_exc), .flush_bp(d_flush_bp),
        .bp_keep_mask(d_keep), .stall_id(d_stall_id), .stall_ex(d_stall_ex),
        .in_valid(d_in_valid), .in_addr(d_in_addr), .in_payload(d_in_payload),
        .in_dslot_next(d_in_dslot), .out_valid(d_out_valid), .out_addr(d_out_addr),
        .out_payload(d_out_payload), .out_dslot_next(d_out_dslot),
        .bubble_cnt(d_bubble_cnt), .flush_cnt(d_flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_a;
        int exp_s;
        // reset with every other input busy
        rst = 1'b1; flush_exc = 1'b0; flush_bp = 1'b1; bp_keep_mask = 2'b11;
        stall_id = 1'b1; stall_ex = 1'b0; in_valid = 2'b11; in_dslot_next = 1'b1;
        in_addr = {32'h1234_5678, 32'h8765_4321}; in_payload = {P1, P0};
        d_rst = 1'b1; d_flush_exc = 1'b0; d_flush_bp = 1'b0; d_keep = 4'b0000;
        d_stall_id = 1'b0; d_stall_ex = 1'b0; d_in_valid = 4'b0000; d_in_dslot = 1'b0;
        d_in_addr = '0; d_in_payload = '0;
        step();
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_addr", 256'(out_addr), 256'(0));
        chk("rst_payload_l0", 256'(out_payload[191:0]), 256'(0));
        chk("rst_dslot", 256'(out_dslot_next), 256'(0));
        flush_exc = 1'b1;
        step();
        chk("rst2_flush_cnt", 256'(flush_cnt), 256'(0));
        chk("rst2_bubble_cnt", 256'(bubble_cnt), 256'(0));
        chk("rst2_valid", 256'(out_valid), 256'(0));

        // load
        rst = 1'b0; flush_exc = 1'b0; flush_bp = 1'b0; stall_id = 1'b0;
        in_valid = 2'b11; in_dslot_next = 1'b0;
        in_addr = {32'hBFC0_0004, 32'hBFC0_0000}; in_payload = {P1, P0};
        step();
        chk("load_valid", 256'(out_valid), 256'(2'b11));
        chk("load_addr", 256'(out_addr), 256'({32'hBFC0_0004, 32'hBFC0_0000}));
        chk("load_payload_l0", 256'(out_payload[191:0]), 256'(P0));
        chk("load_payload_l1", 256'(out_payload[383:192]), 256'(P1));

        // bubble
        stall_id = 1'b1; stall_ex = 1'b0; in_dslot_next = 1'b1;
        in_addr = {32'hDEAD_0004, 32'hDEAD_0000};
        step();
        chk("bub_valid", 256'(out_valid), 256'(0));
        chk("bub_addr", 256'(out_addr), 256'(0));
        chk("bub_payload_l1", 256'(out_payload[383:192]), 256'(0));
        chk("bub_dslot", 256'(out_dslot_next), 256'(1));
        chk("bub_cnt", 256'(bubble_cnt), 256'(1));
        chk("bub_flush_cnt", 256'(flush_cnt), 256'(0));

        // reload then hold for 3 cycles
        stall_id = 1'b0; in_dslot_next = 1'b0; in_valid = 2'b10;
        in_addr = {32'h8000_0004, 32'h8000_0000};
        step();
        chk("reload_valid", 256'(out_valid), 256'(2'b10));
        stall_id = 1'b1; stall_ex = 1'b1; in_valid = 2'b11; in_dslot_next = 1'b1;
        in_addr = {32'hFFFF_0004, 32'hFFFF_0000};
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_valid", 256'(out_valid), 256'(2'b10));
            chk("hold_addr", 256'(out_addr), 256'({32'h8000_0004, 32'h8000_0000}));
            chk("hold_dslot", 256'(out_dslot_next), 256'(0));
            chk("hold_bub_cnt", 256'(bubble_cnt), 256'(1));
        end

        // branch mispredict, keep lane 0 only, while stalled
        flush_bp = 1'b1; bp_keep_mask = 2'b01; in_valid = 2'b11;
        in_addr = {32'h8000_100C, 32'h8000_1008}; in_payload = {P1, Q0};
        step();
        chk("bp01_valid", 256'(out_valid), 256'(2'b01));
        chk("bp01_addr", 256'(out_addr), 256'({32'h0, 32'h8000_1008}));
        chk("bp01_payload_l0", 256'(out_payload[191:0]), 256'(Q0));
        chk("bp01_payload_l1", 256'(out_payload[383:192]), 256'(0));
        chk("bp01_dslot", 256'(out_dslot_next), 256'(1));
        chk("bp01_flush_cnt", 256'(flush_cnt), 256'(1));
        chk("bp01_bub_cnt", 256'(bubble_cnt), 256'(1));

        // mask with gap at lane 0 kills everything
        bp_keep_mask = 2'b10; in_dslot_next = 1'b0;
        step();
        chk("bp10_valid", 256'(out_valid), 256'(0));
        chk("bp10_addr", 256'(out_addr), 256'(0));
        chk("bp10_dslot", 256'(out_dslot_next), 256'(0));
        chk("bp10_flush_cnt", 256'(flush_cnt), 256'(2));

        bp_keep_mask = 2'b11; stall_id = 1'b0; stall_ex = 1'b0;
        step();
        chk("bp11_valid", 256'(out_valid), 256'(2'b11));
        chk("bp11_addr", 256'(out_addr), 256'({32'h8000_100C, 32'h8000_1008}));
        chk("bp11_flush_cnt", 256'(flush_cnt), 256'(3));

        // simultaneous exception + mispredict
        flush_exc = 1'b1; flush_bp = 1'b1; stall_ex = 1'b1; in_dslot_next = 1'b1;
        step();
        chk("exc_valid", 256'(out_valid), 256'(0));
        chk("exc_addr", 256'(out_addr), 256'(0));
        chk("exc_payload_l0", 256'(out_payload[191:0]), 256'(0));
        chk("exc_dslot", 256'(out_dslot_next), 256'(0));
        chk("exc_flush_cnt", 256'(flush_cnt), 256'(4));
        chk("exc_sat_flush_cnt", 256'(s_flush_cnt), 256'(4));

        // 20 bubbles: 16-bit counter keeps counting, 4-bit counter pins at 15
        flush_exc = 1'b0; flush_bp = 1'b0; stall_id = 1'b1; stall_ex = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_a = 1 + k;
            exp_s = (exp_a > 15) ? 15 : exp_a;
            chk("sat_bub_cnt", 256'(s_bubble_cnt), 256'(exp_s));
            chk("wide_bub_cnt", 256'(bubble_cnt), 256'(exp_a));
        end
        chk("sat_valid", 256'(s_out_valid), 256'(0));
        rst = 1'b1;
        step();
        chk("midrst_sat_cnt", 256'(s_bubble_cnt), 256'(0));
        chk("midrst_wide_cnt", 256'(bubble_cnt), 256'(0));
        chk("midrst_flush_cnt", 256'(flush_cnt), 256'(0));
        rst = 1'b0;
        step();
        chk("post_rst_sat_cnt", 256'(s_bubble_cnt), 256'(1));

        // 4-lane, kill holds addr/payload
        d_rst = 1'b0; d_in_valid = 4'b1111;
        d_in_addr = {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000};
        d_in_payload = {P_A5, P_A5, P_A5, P_A5};
        step();
        chk("d4_load_valid", 256'(d_out_valid), 256'(4'b1111));
        chk("d4_load_payload_l3", 256'(d_out_payload[767:576]), 256'(P_A5));
        d_stall_id = 1'b1;
        d_in_payload = {P_5A, P_5A, P_5A, P_5A};
        step();
        chk("d4_bub_valid", 256'(d_out_valid), 256'(0));
        chk("d4_bub_payload_l0", 256'(d_out_payload[191:0]), 256'(P_A5));
        chk("d4_bub_payload_l3", 256'(d_out_payload[767:576]), 256'(P_A5));
        chk("d4_bub_addr_l2", 256'(d_out_addr[95:64]), 256'(32'h0000_1008));
        chk("d4_bub_cnt", 256'(d_bubble_cnt), 256'(1));
        // non-contiguous mask 1011 truncates to lanes 0..1
        d_flush_bp = 1'b1; d_keep = 4'b1011;
        step();
        chk("d4_bp_valid", 256'(d_out_valid), 256'(4'b0011));
        chk("d4_bp_payload_l1", 256'(d_out_payload[383:192]), 256'(P_5A));
        chk("d4_bp_payload_l3", 256'(d_out_payload[767:576]), 256'(P_A5));
        chk("d4_bp_flush_cnt", 256'(d_flush_cnt), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
